// File: rtl/llc_cdc_dst_bridge.sv
// Destination (soc_clk) end of the LLC async-FIFO link: drains AW/W/AR from SoC-held slots, owns B/R storage.
// Rx latency SyncStages cycles (+1 with LLC_CDC_DST_SPILL_EN); valid/ready backpressure, b/r ready drops on conservative full.

// Receive channel: read side of one async FIFO whose slots live in the remote domain.
module llc_cdc_dst_rx #(
   parameter int LogDepth   = 3,
   parameter int SyncStages = 2,
   parameter int Width      = 64
) (
   input  logic                           soc_clk,
   input  logic                           rst_n,
   input  logic [(2**LogDepth)*Width-1:0] data_i,
   input  logic [LogDepth:0]              wptr_i,
   output logic [LogDepth:0]              rptr_o,
   output logic [Width-1:0]               dat_o,
   output logic                           vld_o,
   input  logic                           rdy_i
);
   localparam logic [LogDepth:0] MaxOcc = (LogDepth + 1)'(2 ** LogDepth);

   logic [SyncStages-1:0][LogDepth:0] sync_q;
   logic [LogDepth:0]   wptr_sync, rptr_bin_q, rptr_bin_d, rptr_gray_q, occ;
   logic [LogDepth-1:0] rd_idx;
   logic [Width-1:0]    fifo_dat;
   logic                fifo_vld, fifo_rdy, pop;

   function automatic logic [LogDepth:0] gray2bin(input logic [LogDepth:0] g);
      logic [LogDepth:0] b;
      b[LogDepth] = g[LogDepth];
      for (int i = LogDepth - 1; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
      return b;
   endfunction

   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= wptr_i;
         for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i - 1];
      end
   end

   assign wptr_sync  = sync_q[SyncStages-1];
   assign fifo_vld   = (rptr_gray_q != wptr_sync);
   assign rd_idx     = rptr_bin_q[LogDepth-1:0];
   assign fifo_dat   = data_i[rd_idx*Width +: Width];
   assign pop        = fifo_vld & fifo_rdy;
   assign rptr_bin_d = rptr_bin_q + (LogDepth + 1)'(1);

   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_bin_q  <= '0;
         rptr_gray_q <= '0;
      end else if (pop) begin
         rptr_bin_q  <= rptr_bin_d;
         rptr_gray_q <= rptr_bin_d ^ (rptr_bin_d >> 1);
      end
   end

   assign rptr_o = rptr_gray_q;

`ifdef LLC_CDC_DST_SPILL_EN
   logic             out_vld_q, skid_vld_q;
   logic [Width-1:0] out_dat_q, skid_dat_q;

   // The skid entry only fills when the output stalls, so a stream at ready=1 runs one beat per cycle.
   assign fifo_rdy = !skid_vld_q;

   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         out_dat_q  <= '0;
         skid_dat_q <= '0;
      end else if (rdy_i || !out_vld_q) begin
         if (skid_vld_q) begin
            out_dat_q  <= skid_dat_q;
            out_vld_q  <= 1'b1;
            skid_vld_q <= 1'b0;
         end else begin
            out_vld_q <= fifo_vld;
            if (fifo_vld) out_dat_q <= fifo_dat;
         end
      end else if (pop) begin
         skid_dat_q <= fifo_dat;
         skid_vld_q <= 1'b1;
      end
   end

   assign vld_o = out_vld_q;
   assign dat_o = out_dat_q;
`else
   assign fifo_rdy = rdy_i;
   assign vld_o    = fifo_vld;
   assign dat_o    = fifo_dat;
`endif

   // A pointer pair more than one FIFO apart means only one side went through reset.
   assign occ = gray2bin(wptr_sync) - rptr_bin_q;
   a_rx_occ: assert property (@(posedge soc_clk) disable iff (!rst_n) occ <= MaxOcc);
endmodule

// Send channel: write side of one async FIFO whose slots are owned here and read remotely.
module llc_cdc_dst_tx #(
   parameter int LogDepth   = 3,
   parameter int SyncStages = 2,
   parameter int Width      = 8
) (
   input  logic                           soc_clk,
   input  logic                           rst_n,
   output logic [(2**LogDepth)*Width-1:0] data_o,
   output logic [LogDepth:0]              wptr_o,
   input  logic [LogDepth:0]              rptr_i,
   input  logic [Width-1:0]               dat_i,
   input  logic                           vld_i,
   output logic                           rdy_o
);
   localparam logic [LogDepth:0] MaxOcc = (LogDepth + 1)'(2 ** LogDepth);

   logic [SyncStages-1:0][LogDepth:0] sync_q;
   logic [(2**LogDepth)*Width-1:0]    slots_q;
   logic [LogDepth:0]   rptr_sync, wptr_bin_q, wptr_bin_d, wptr_gray_q, occ;
   logic [LogDepth-1:0] wr_idx;
   logic                full, push;

   function automatic logic [LogDepth:0] gray2bin(input logic [LogDepth:0] g);
      logic [LogDepth:0] b;
      b[LogDepth] = g[LogDepth];
      for (int i = LogDepth - 1; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
      return b;
   endfunction

   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= rptr_i;
         for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i - 1];
      end
   end

   assign rptr_sync  = sync_q[SyncStages-1];
   assign full       = (wptr_gray_q == {~rptr_sync[LogDepth:LogDepth-1], rptr_sync[LogDepth-2:0]});
   assign rdy_o      = !full;
   assign push       = vld_i & !full;
   assign wr_idx     = wptr_bin_q[LogDepth-1:0];
   assign wptr_bin_d = wptr_bin_q + (LogDepth + 1)'(1);

   // Slot and pointer move on the same edge; the remote side only sees the pointer after its own synchroniser.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         slots_q     <= '0;
         wptr_bin_q  <= '0;
         wptr_gray_q <= '0;
      end else if (push) begin
         slots_q[wr_idx*Width +: Width] <= dat_i;
         wptr_bin_q  <= wptr_bin_d;
         wptr_gray_q <= wptr_bin_d ^ (wptr_bin_d >> 1);
      end
   end

   assign data_o = slots_q;
   assign wptr_o = wptr_gray_q;

   assign occ = wptr_bin_q - gray2bin(rptr_sync);
   a_tx_occ: assert property (@(posedge soc_clk) disable iff (!rst_n) occ <= MaxOcc);
endmodule

module llc_cdc_dst_bridge #(
   parameter int LogDepth   = 3,
   parameter int SyncStages = 2,
   parameter int AwWidth    = 64,
   parameter int WWidth     = 73,
   parameter int BWidth     = 8,
   parameter int ArWidth    = 64,
   parameter int RWidth     = 72
) (
   input  logic                             soc_clk,
   input  logic                             rst_n,
   input  logic [(2**LogDepth)*AwWidth-1:0] llc_aw_data_i,
   input  logic [LogDepth:0]                llc_aw_wptr_i,
   output logic [LogDepth:0]                llc_aw_rptr_o,
   input  logic [(2**LogDepth)*WWidth-1:0]  llc_w_data_i,
   input  logic [LogDepth:0]                llc_w_wptr_i,
   output logic [LogDepth:0]                llc_w_rptr_o,
   input  logic [(2**LogDepth)*ArWidth-1:0] llc_ar_data_i,
   input  logic [LogDepth:0]                llc_ar_wptr_i,
   output logic [LogDepth:0]                llc_ar_rptr_o,
   output logic [(2**LogDepth)*BWidth-1:0]  llc_b_data_o,
   output logic [LogDepth:0]                llc_b_wptr_o,
   input  logic [LogDepth:0]                llc_b_rptr_i,
   output logic [(2**LogDepth)*RWidth-1:0]  llc_r_data_o,
   output logic [LogDepth:0]                llc_r_wptr_o,
   input  logic [LogDepth:0]                llc_r_rptr_i,
   output logic [AwWidth-1:0]               aw_o,
   output logic                             aw_valid_o,
   input  logic                             aw_ready_i,
   output logic [WWidth-1:0]                w_o,
   output logic                             w_valid_o,
   input  logic                             w_ready_i,
   output logic [ArWidth-1:0]               ar_o,
   output logic                             ar_valid_o,
   input  logic                             ar_ready_i,
   input  logic [BWidth-1:0]                b_i,
   input  logic                             b_valid_i,
   output logic                             b_ready_o,
   input  logic [RWidth-1:0]                r_i,
   input  logic                             r_valid_i,
   output logic                             r_ready_o
);
   llc_cdc_dst_rx #(.LogDepth(LogDepth), .SyncStages(SyncStages), .Width(AwWidth)) u_aw (
      .soc_clk(soc_clk), .rst_n(rst_n), .data_i(llc_aw_data_i), .wptr_i(llc_aw_wptr_i),
      .rptr_o(llc_aw_rptr_o), .dat_o(aw_o), .vld_o(aw_valid_o), .rdy_i(aw_ready_i));

   llc_cdc_dst_rx #(.LogDepth(LogDepth), .SyncStages(SyncStages), .Width(WWidth)) u_w (
      .soc_clk(soc_clk), .rst_n(rst_n), .data_i(llc_w_data_i), .wptr_i(llc_w_wptr_i),
      .rptr_o(llc_w_rptr_o), .dat_o(w_o), .vld_o(w_valid_o), .rdy_i(w_ready_i));

   llc_cdc_dst_rx #(.LogDepth(LogDepth), .SyncStages(SyncStages), .Width(ArWidth)) u_ar (
      .soc_clk(soc_clk), .rst_n(rst_n), .data_i(llc_ar_data_i), .wptr_i(llc_ar_wptr_i),
      .rptr_o(llc_ar_rptr_o), .dat_o(ar_o), .vld_o(ar_valid_o), .rdy_i(ar_ready_i));

   llc_cdc_dst_tx #(.LogDepth(LogDepth), .SyncStages(SyncStages), .Width(BWidth)) u_b (
      .soc_clk(soc_clk), .rst_n(rst_n), .data_o(llc_b_data_o), .wptr_o(llc_b_wptr_o),
      .rptr_i(llc_b_rptr_i), .dat_i(b_i), .vld_i(b_valid_i), .rdy_o(b_ready_o));

   llc_cdc_dst_tx #(.LogDepth(LogDepth), .SyncStages(SyncStages), .Width(RWidth)) u_r (
      .soc_clk(soc_clk), .rst_n(rst_n), .data_o(llc_r_data_o), .wptr_o(llc_r_wptr_o),
      .rptr_i(llc_r_rptr_i), .dat_i(r_i), .vld_i(r_valid_i), .rdy_o(r_ready_o));
endmodule

// File: tb/tb_llc_cdc_dst_bridge.sv
// Bench for llc_cdc_dst_bridge: remote SoC side modelled here, scoreboard queues per channel.
module tb_llc_cdc_dst_bridge;
   localparam int LD = 3, SS = 2, D = 8;
   localparam int AWW = 64, WW = 73, BW = 8, ARW = 64, RW = 72;
`ifdef LLC_CDC_DST_SPILL_EN
   localparam int RxLat = SS + 1;
`else
   localparam int RxLat = SS;
`endif

   logic             soc_clk, rst_n;
   logic [D*AWW-1:0] llc_aw_data_i;
   logic [D*WW-1:0]  llc_w_data_i;
   logic [D*ARW-1:0] llc_ar_data_i;
   logic [D*BW-1:0]  llc_b_data_o;
   logic [D*RW-1:0]  llc_r_data_o;
   logic [LD:0]      llc_aw_wptr_i, llc_aw_rptr_o, llc_w_wptr_i, llc_w_rptr_o;
   logic [LD:0]      llc_ar_wptr_i, llc_ar_rptr_o, llc_b_wptr_o, llc_b_rptr_i;
   logic [LD:0]      llc_r_wptr_o, llc_r_rptr_i;
   logic [AWW-1:0]   aw_o;
   logic [WW-1:0]    w_o;
   logic [ARW-1:0]   ar_o;
   logic [BW-1:0]    b_i;
   logic [RW-1:0]    r_i;
   logic aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, ar_valid_o, ar_ready_i;
   logic b_valid_i, b_ready_o, r_valid_i, r_ready_o;

   int n_pass = 0;
   int n_chk  = 0;

   logic [AWW-1:0] aw_q[$];
   logic [WW-1:0]  w_q[$];
   logic [ARW-1:0] ar_q[$];
   logic [BW-1:0]  b_q[$];

   llc_cdc_dst_bridge #(
      .LogDepth(LD), .SyncStages(SS), .AwWidth(AWW), .WWidth(WW),
      .BWidth(BW), .ArWidth(ARW), .RWidth(RW)
   ) dut (
      .soc_clk(soc_clk), .rst_n(rst_n),
      .llc_aw_data_i(llc_aw_data_i), .llc_aw_wptr_i(llc_aw_wptr_i), .llc_aw_rptr_o(llc_aw_rptr_o),
      .llc_w_data_i(llc_w_data_i), .llc_w_wptr_i(llc_w_wptr_i), .llc_w_rptr_o(llc_w_rptr_o),
      .llc_ar_data_i(llc_ar_data_i), .llc_ar_wptr_i(llc_ar_wptr_i), .llc_ar_rptr_o(llc_ar_rptr_o),
      .llc_b_data_o(llc_b_data_o), .llc_b_wptr_o(llc_b_wptr_o), .llc_b_rptr_i(llc_b_rptr_i),
      .llc_r_data_o(llc_r_data_o), .llc_r_wptr_o(llc_r_wptr_o), .llc_r_rptr_i(llc_r_rptr_i),
      .aw_o(aw_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .w_o(w_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
      .ar_o(ar_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .b_i(b_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .r_i(r_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
   );

   initial soc_clk = 1'b0;
   always #5 soc_clk = ~soc_clk;

   function automatic logic [3:0] g4(input int b);
      logic [3:0] x;
      x = 4'(b);
      return x ^ (x >> 1);
   endfunction

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
      return b;
   endfunction

   task automatic tick();
      @(posedge soc_clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      llc_aw_data_i = '0; llc_w_data_i = '0; llc_ar_data_i = '0;
      llc_aw_wptr_i = '0; llc_w_wptr_i = '0; llc_ar_wptr_i = '0;
      llc_b_rptr_i = '0; llc_r_rptr_i = '0;
      aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
      b_i = '0; b_valid_i = 1'b0; r_i = '0; r_valid_i = 1'b0;
      repeat (3) tick();
      n_chk++;
      if ({llc_aw_rptr_o, llc_w_rptr_o, llc_ar_rptr_o, llc_b_wptr_o, llc_r_wptr_o} !== 20'h0)
         $display("FAIL rst_ptrs_in_reset got %h want 0",
                  {llc_aw_rptr_o, llc_w_rptr_o, llc_ar_rptr_o, llc_b_wptr_o, llc_r_wptr_o});
      else n_pass++;
      rst_n = 1'b1;
      repeat (3) tick();
      n_chk++;
      if ({aw_valid_o, w_valid_o, ar_valid_o} !== 3'b000)
         $display("FAIL rst_valid got %b want 000", {aw_valid_o, w_valid_o, ar_valid_o});
      else n_pass++;
      n_chk++;
      if ({b_ready_o, r_ready_o} !== 2'b11)
         $display("FAIL rst_ready got %b want 11", {b_ready_o, r_ready_o});
      else n_pass++;
      n_chk++;
      if ({llc_aw_rptr_o, llc_w_rptr_o, llc_ar_rptr_o, llc_b_wptr_o, llc_r_wptr_o} !== 20'h0)
         $display("FAIL rst_ptrs got %h want 0",
                  {llc_aw_rptr_o, llc_w_rptr_o, llc_ar_rptr_o, llc_b_wptr_o, llc_r_wptr_o});
      else n_pass++;
      n_chk++;
      if (llc_b_data_o !== '0 || llc_r_data_o !== '0)
         $display("FAIL rst_slots b=%h r=%h want 0", llc_b_data_o, llc_r_data_o);
      else n_pass++;
   endtask

   task automatic test_aw_latency();
      logic [AWW-1:0] pat, exp_d;
      pat = 64'hA5A5_A5A5_A5A5_A5A5;
      llc_aw_data_i[0 +: AWW] = pat;
      aw_ready_i = 1'b1;
      llc_aw_wptr_i = 4'b0001;
      aw_q.push_back(pat);
      for (int n = 1; n <= RxLat; n++) begin
         tick();
         n_chk++;
         if (aw_valid_o !== (n == RxLat))
            $display("FAIL aw_latency cycle %0d got valid=%b want %b", n, aw_valid_o, (n == RxLat));
         else n_pass++;
      end
      if (aw_valid_o && aw_ready_i && aw_q.size() > 0) begin
         exp_d = aw_q.pop_front();
         n_chk++;
         if (aw_o !== exp_d) $display("FAIL aw_data got %h want %h", aw_o, exp_d);
         else n_pass++;
      end
      tick();
      n_chk++;
      if (llc_aw_rptr_o !== 4'b0001) $display("FAIL aw_rptr got %b want 0001", llc_aw_rptr_o);
      else n_pass++;
      n_chk++;
      if (aw_valid_o !== 1'b0 || aw_q.size() != 0)
         $display("FAIL aw_drained got valid=%b pending=%0d want 0/0", aw_valid_o, aw_q.size());
      else n_pass++;
   endtask

   task automatic test_b_fill();
      logic [BW-1:0] exp_d;
      llc_b_rptr_i = '0;
      for (int k = 0; k < D; k++) begin
         b_i = 8'(16 + k);
         b_valid_i = 1'b1;
         n_chk++;
         if (b_ready_o !== 1'b1) $display("FAIL b_fill_rdy beat %0d got %b want 1", k, b_ready_o);
         else n_pass++;
         b_q.push_back(b_i);
         tick();
      end
      b_valid_i = 1'b0;
      n_chk++;
      if (b_ready_o !== 1'b0) $display("FAIL b_full_rdy got %b want 0", b_ready_o);
      else n_pass++;
      n_chk++;
      if (llc_b_wptr_o !== 4'b1100) $display("FAIL b_wptr_full got %b want 1100", llc_b_wptr_o);
      else n_pass++;
      for (int k = 0; k < D; k++) begin
         exp_d = b_q.pop_front();
         n_chk++;
         if (llc_b_data_o[k*BW +: BW] !== exp_d)
            $display("FAIL b_slot%0d got %h want %h", k, llc_b_data_o[k*BW +: BW], exp_d);
         else n_pass++;
      end
   endtask

   task automatic test_b_reopen();
      logic [BW-1:0] exp_d;
      llc_b_rptr_i = 4'b0001;
      for (int n = 1; n <= SS; n++) begin
         tick();
         n_chk++;
         if (b_ready_o !== (n == SS))
            $display("FAIL b_reopen cycle %0d got %b want %b", n, b_ready_o, (n == SS));
         else n_pass++;
      end
      b_i = 8'h99;
      b_valid_i = 1'b1;
      b_q.push_back(b_i);
      tick();
      b_valid_i = 1'b0;
      exp_d = b_q.pop_front();
      n_chk++;
      if (llc_b_data_o[0 +: BW] !== exp_d)
         $display("FAIL b_slot0_wrap got %h want %h", llc_b_data_o[0 +: BW], exp_d);
      else n_pass++;
      n_chk++;
      if (llc_b_data_o[BW +: BW] !== 8'h11)
         $display("FAIL b_slot1_kept got %h want 11", llc_b_data_o[BW +: BW]);
      else n_pass++;
      n_chk++;
      if (llc_b_wptr_o !== 4'b1101) $display("FAIL b_wptr9 got %b want 1101", llc_b_wptr_o);
      else n_pass++;
      n_chk++;
      if (b_ready_o !== 1'b0) $display("FAIL b_refull got %b want 0", b_ready_o);
      else n_pass++;
   endtask

   task automatic test_ar_stream();
      int sent = 0, got = 0, cyc = 0;
      logic [3:0] wbin = '0;
      logic [3:0] occ;
      logic stall_prev = 1'b0;
      logic [ARW-1:0] held = '0, exp_d, d;
      while (got < 20 && cyc < 2000) begin
         ar_ready_i = 1'($urandom_range(0, 1));
         if (stall_prev) begin
            n_chk++;
            if (ar_valid_o !== 1'b1 || ar_o !== held)
               $display("FAIL ar_hold got valid=%b data=%h want 1/%h", ar_valid_o, ar_o, held);
            else n_pass++;
         end
         if (ar_valid_o && ar_ready_i) begin
            if (ar_q.size() == 0) begin
               n_chk++;
               $display("FAIL ar_extra got %h want nothing", ar_o);
            end else begin
               exp_d = ar_q.pop_front();
               n_chk++;
               if (ar_o !== exp_d) $display("FAIL ar_data beat %0d got %h want %h", got, ar_o, exp_d);
               else n_pass++;
            end
            got++;
         end
         stall_prev = ar_valid_o && !ar_ready_i;
         held = ar_o;
         occ = wbin - g2b(llc_ar_rptr_o);
         if (sent < 20 && occ < 4'd8 && $urandom_range(0, 3) != 0) begin
            d = {$urandom, $urandom};
            llc_ar_data_i[int'(wbin[2:0])*ARW +: ARW] = d;
            wbin = wbin + 4'd1;
            llc_ar_wptr_i = wbin ^ (wbin >> 1);
            ar_q.push_back(d);
            sent++;
         end
         tick();
         cyc++;
      end
      if (got < 20) begin
         n_chk++;
         $display("FAIL ar_timeout got %0d beats want 20", got);
      end
      ar_ready_i = 1'b0;
      tick();
      n_chk++;
      if (llc_ar_rptr_o !== g4(20)) $display("FAIL ar_rptr_final got %b want %b", llc_ar_rptr_o, g4(20));
      else n_pass++;
      n_chk++;
      if (ar_valid_o !== 1'b0 || ar_q.size() != 0)
         $display("FAIL ar_drained got valid=%b pending=%0d want 0/0", ar_valid_o, ar_q.size());
      else n_pass++;
   endtask

   task automatic test_w_reset();
      int seen = 0;
      bit done = 0;
      logic [WW-1:0] d, exp_d;
      w_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) llc_w_data_i[k*WW +: WW] = {9'(k), $urandom, $urandom};
      llc_w_wptr_i = g4(3);
      repeat (RxLat + 1) tick();
      n_chk++;
      if (w_valid_o !== 1'b1) $display("FAIL w_pending got %b want 1", w_valid_o);
      else n_pass++;
      rst_n = 1'b0;
      llc_aw_wptr_i = '0; llc_w_wptr_i = '0; llc_ar_wptr_i = '0;
      llc_b_rptr_i = '0; llc_r_rptr_i = '0;
      #1;
      n_chk++;
      if (w_valid_o !== 1'b0 || llc_w_rptr_o !== 4'b0000)
         $display("FAIL w_in_reset got valid=%b rptr=%b want 0/0000", w_valid_o, llc_w_rptr_o);
      else n_pass++;
      repeat (2) tick();
      n_chk++;
      if ({llc_aw_rptr_o, llc_ar_rptr_o, llc_b_wptr_o} !== 12'h0 || b_ready_o !== 1'b1)
         $display("FAIL reset_mid_ptrs got %h rdy=%b want 0/1",
                  {llc_aw_rptr_o, llc_ar_rptr_o, llc_b_wptr_o}, b_ready_o);
      else n_pass++;
      rst_n = 1'b1;
      w_ready_i = 1'b1;
      repeat (10) begin
         tick();
         if (w_valid_o) seen++;
      end
      n_chk++;
      if (seen != 0) $display("FAIL w_stale got %0d beats want 0", seen);
      else n_pass++;
      d = {9'h1AB, $urandom, $urandom};
      llc_w_data_i[0 +: WW] = d;
      llc_w_wptr_i = 4'b0001;
      w_q.push_back(d);
      for (int c = 0; c < 20 && !done; c++) begin
         tick();
         if (w_valid_o && w_ready_i) begin
            exp_d = w_q.pop_front();
            n_chk++;
            if (w_o !== exp_d) $display("FAIL w_after_reset got %h want %h", w_o, exp_d);
            else n_pass++;
            done = 1;
         end
      end
      if (!done) begin
         n_chk++;
         $display("FAIL w_after_reset_timeout got no beat want 1");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_aw_latency();
      test_b_fill();
      test_b_reopen();
      test_ar_stream();
      test_w_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
